// File: rtl/reg_bank_disp.sv
// Register bank with two combinational read ports, one write port and a
// multiplexed 7-segment hex display of both read ports.
// Optional macro REGFILE_BYPASS_EN forwards write data to a colliding read port.
module reg_bank_disp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addrRa,
    input  logic [ADDR_W-1:0]     addrRb,
    input  logic [ADDR_W-1:0]     addrW,
    input  logic [DATA_W-1:0]     datW,
    input  logic                  regWrite,
    output logic [DATA_W-1:0]     datOutRa,
    output logic [DATA_W-1:0]     datOutRb,
    output logic [6:0]            SSeg,
    output logic [DATA_W/2-1:0]   An
);

    localparam int DIGITS = DATA_W / 2;
    localparam int HALF   = DIGITS / 2;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [31:0]       scan_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic [3:0]        nibble;
    logic [6:0]        seg_code;
    logic              scan_wrap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (regWrite) begin
            regs[addrW] <= datW;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign datOutRa = (regWrite && (addrRa == addrW)) ? datW : regs[addrRa];
    assign datOutRb = (regWrite && (addrRb == addrW)) ? datW : regs[addrRb];
`else
    assign datOutRa = regs[addrRa];
    assign datOutRb = regs[addrRb];
`endif

    // Lower digit indices show port A nibbles, upper indices show port B.
    always_comb begin
        nibble = '0;
        for (int i = 0; i < HALF; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                nibble = datOutRa[i*4 +: 4];
            end
            if (digit_idx == IDX_W'(i + HALF)) begin
                nibble = datOutRb[i*4 +: 4];
            end
        end
    end

    always_comb begin
        seg_code = 7'h7F;
        case (nibble)
            4'h0: seg_code = 7'h40;
            4'h1: seg_code = 7'h79;
            4'h2: seg_code = 7'h24;
            4'h3: seg_code = 7'h30;
            4'h4: seg_code = 7'h19;
            4'h5: seg_code = 7'h12;
            4'h6: seg_code = 7'h02;
            4'h7: seg_code = 7'h78;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h10;
            4'hA: seg_code = 7'h08;
            4'hB: seg_code = 7'h03;
            4'hC: seg_code = 7'h46;
            4'hD: seg_code = 7'h21;
            4'hE: seg_code = 7'h06;
            4'hF: seg_code = 7'h0E;
            default: seg_code = 7'h7F;
        endcase
    end

    assign scan_wrap = (scan_cnt == 32'(SCAN_DIV - 1));

    // The digit at digit_idx is latched onto the outputs as the index advances.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            An        <= '1;
            SSeg      <= 7'h7F;
        end else if (scan_wrap) begin
            scan_cnt  <= '0;
            An        <= ~(DIGITS'(1) << digit_idx);
            SSeg      <= seg_code;
            digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_reg_bank_disp.sv
// Self-checking bench for reg_bank_disp: a behavioural model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_reg_bank_disp;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int SCAN_DIV = 4;
    localparam int DIGITS   = DATA_W / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  addrRa = '0;
    logic [3:0]  addrRb = '0;
    logic [3:0]  addrW = '0;
    logic [7:0]  datW = '0;
    logic        regWrite = 1'b0;
    logic [7:0]  datOutRa;
    logic [7:0]  datOutRb;
    logic [6:0]  SSeg;
    logic [3:0]  An;

    int errors = 0;
    int checks = 0;

    reg_bank_disp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .addrRa(addrRa), .addrRb(addrRb), .addrW(addrW),
        .datW(datW), .regWrite(regWrite), .datOutRa(datOutRa), .datOutRb(datOutRb),
        .SSeg(SSeg), .An(An)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Behavioural model: register contents, cycles since reset, expected display.
    logic [7:0]  m_mem [16];
    int unsigned m_cyc = 0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_sseg = 7'h7F;
    bit          model_ok = 1'b0;

    function automatic logic [7:0] m_read(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
        if (regWrite && a == addrW) return datW;
`endif
        return m_mem[a];
    endfunction

    always @(posedge clk) begin
        int unsigned nc;
        int k;
        logic [7:0] v;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= '0;
            m_cyc    <= 0;
            exp_an   <= 4'hF;
            exp_sseg <= 7'h7F;
            model_ok <= 1'b1;
        end else begin
            nc = m_cyc + 1;
            m_cyc <= nc;
            if (nc % SCAN_DIV == 0) begin
                k = int'((nc / SCAN_DIV - 1) % DIGITS);
                v = (k < DIGITS / 2) ? m_read(addrRa) : m_read(addrRb);
                v = v >> (4 * (k % (DIGITS / 2)));
                exp_an   <= 4'hF ^ (4'h1 << k);
                exp_sseg <= hex_table[v[3:0]];
            end
            if (regWrite) m_mem[addrW] <= datW;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic we, input logic [3:0] wa, input logic [7:0] wd);
        @(negedge clk);
        rst = r; addrRa = ra; addrRb = rb; regWrite = we; addrW = wa; datW = wd;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        #2;
        if (model_ok) begin
            checkOutput("cmp_ra", datOutRa, m_read(addrRa));
            checkOutput("cmp_rb", datOutRb, m_read(addrRb));
            checkOutput("cmp_an", An, exp_an);
            checkOutput("cmp_sseg", SSeg, exp_sseg);
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        $display("[TB] starting");
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00);
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 4'(a), 4'd0, 1'b0, 4'd0, 8'h00);
            #1;
            checkOutput("reset_ra", datOutRa, 0);
        end
        checkOutput("reset_an", An, 4'hF);
        checkOutput("reset_sseg", SSeg, 7'h7F);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'd0, 4'd0, 1'b1, 4'(i), 8'(i * 17));
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 4'((i + 8) % 16), 1'b0, 4'd0, 8'h00);
            #1;
            checkOutput("wr_ra", datOutRa, i * 17);
            checkOutput("wr_rb", datOutRb, ((i + 8) % 16) * 17);
        end

        applyStimulus(1'b1, 4'd5, 4'd0, 1'b1, 4'd5, 8'h55);
        applyStimulus(1'b1, 4'd5, 4'd0, 1'b1, 4'd5, 8'hA7);
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("coll_before", datOutRa, 8'hA7);
`else
        checkOutput("coll_before", datOutRa, 8'h55);
`endif
        @(posedge clk);
        #1;
        checkOutput("coll_after", datOutRa, 8'hA7);

        // Display sequence from a fresh reset with reg[1]=0x3C, reg[2]=0xF0.
        applyStimulus(1'b0, 4'd1, 4'd2, 1'b0, 4'd0, 8'h00);
        applyStimulus(1'b0, 4'd1, 4'd2, 1'b0, 4'd0, 8'h00);
        applyStimulus(1'b1, 4'd1, 4'd2, 1'b1, 4'd1, 8'h3C);
        applyStimulus(1'b1, 4'd1, 4'd2, 1'b1, 4'd2, 8'hF0);
        applyStimulus(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 8'h00);
        n = 2;
        while (n < 40) begin
            @(negedge clk);
            #2;
            n++;
            if (An != 4'hF) break;
        end
        checkOutput("first_lit_cycle", n, SCAN_DIV);
        checkOutput("disp0_an", An, 4'hE);
        checkOutput("disp0_sseg", SSeg, 7'h46);
        begin
            logic [3:0] an_seq [4] = '{4'hD, 4'hB, 4'h7, 4'hE};
            logic [6:0] sg_seq [4] = '{7'h30, 7'h40, 7'h0E, 7'h46};
            for (int s = 0; s < 4; s++) begin
                repeat (SCAN_DIV) @(negedge clk);
                #2;
                checkOutput("disp_an", An, an_seq[s]);
                checkOutput("disp_sseg", SSeg, sg_seq[s]);
            end
        end

        @(negedge clk);
        addrRa = 4'd0;
        #2;
        checkOutput("hold_sseg", SSeg, 7'h46);
        repeat (SCAN_DIV - 1) @(negedge clk);
        #2;
        checkOutput("next_an", An, 4'hD);
        checkOutput("next_sseg", SSeg, 7'h40);

        applyStimulus(1'b0, 4'd2, 4'd0, 1'b1, 4'd2, 8'hFF);
        applyStimulus(1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 8'h00);
        #1;
        checkOutput("rst_prio_reg2", datOutRa, 0);

        repeat (SCAN_DIV + 1) @(negedge clk);
        #2;
        checkOutput("midscan_lit", An, 4'hE);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("midscan_blank", An, 4'hF);
        checkOutput("midscan_sseg", SSeg, 7'h7F);
        applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00);
        repeat (3) @(negedge clk);
        #3;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_disp.md
REG_BANK_DISP -- requirements
Module: reg_bank_disp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, register width in bits; legal values are multiples of 4 from 4 to 16.
REQ-002 The block SHALL have parameter ADDR_W, default 4, address width; the bank holds 2**ADDR_W registers.
REQ-003 The block SHALL have parameter SCAN_DIV, default 50000, clock cycles each display digit stays lit; legal values are 2 or greater.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port addrRa, input, ADDR_W bits: read port A address.
REQ-007 The block SHALL have port addrRb, input, ADDR_W bits: read port B address.
REQ-008 The block SHALL have port addrW, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port datW, input, DATA_W bits: write data.
REQ-010 The block SHALL have port regWrite, input, 1 bit: write enable, active-high.
REQ-011 The block SHALL have port datOutRa, output, DATA_W bits: read port A data.
REQ-012 The block SHALL have port datOutRb, output, DATA_W bits: read port B data.
REQ-013 The block SHALL have port SSeg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-014 The block SHALL have port An, output, DIGITS bits, where DIGITS = DATA_W/2: digit anodes, active-low, one-hot.

Function
REQ-015 With rst=1 and regWrite=1, a rising edge SHALL store datW in the register at addrW; every address, including 0, is writable.
REQ-016 With regWrite=0, no register SHALL change.
REQ-017 datOutRa and datOutRb SHALL be combinational reads of the registers at addrRa and addrRb, with zero-cycle latency.
REQ-018 When addrRa equals addrRb, both read ports SHALL return the same value.
REQ-019 A 32-bit-or-narrower scan counter SHALL count from 0 to SCAN_DIV-1 and then wrap to 0; each wrap SHALL advance the digit index by one, from 0 up to DIGITS-1 and then back to 0.
REQ-020 Digit index k < DIGITS/2 SHALL display nibble k of datOutRa, with nibble 0 as the LSB; index k >= DIGITS/2 SHALL display nibble k-DIGITS/2 of datOutRb.
REQ-021 SSeg and An SHALL be registered and SHALL update on the same edge the digit index advances; An then has exactly bit k low, and SSeg holds the hex code of the selected nibble.
REQ-022 The display value SHALL be sampled on the advance edge only; data changes within a digit slot SHALL NOT alter SSeg until the next advance.
REQ-023 The hex encoding SHALL be the standard active-low table, for example 0=0x40, 1=0x79, 8=0x00, A=0x08, F=0x0E.

Reset
REQ-024 On a rising edge with rst=0, all registers SHALL clear to 0, the scan counter and digit index SHALL clear to 0, An SHALL become all ones (display blank), and SSeg SHALL become 0x7F.
REQ-025 Reset SHALL have priority over a simultaneous write; a write asserted during reset SHALL be discarded.
REQ-026 After rst is released, the first digit, index 0, SHALL light after SCAN_DIV cycles.
REQ-027 Reset asserted mid-scan SHALL blank the display on that same edge.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, if regWrite=1 and a read address equals addrW, that read port SHALL return datW combinationally in the same cycle.
REQ-029 Without REGFILE_BYPASS_EN, such a read SHALL return the old stored value until the write edge.
REQ-030 Neither macro setting SHALL change the write, reset or display behaviour.

Verification
REQ-031 Reset test: hold rst=0 for 2 cycles, then sweep addrRa 0..15 -> datOutRa=0 at every address; An=0xF; SSeg=0x7F.
REQ-032 Write/read test: write reg[i]=i*16+i for i=0..15, then set addrRa=i and addrRb=i+8 (mod 16) -> both ports return the written values, e.g. addrRa=3 gives 0x33 and addrRb=11 gives 0xBB.
REQ-033 Collision test: regWrite=1, addrW=5, datW=0xA7, addrRa=5, with reg[5]=0x55 -> datOutRa=0xA7 before the edge with the macro defined, 0x55 without it, and 0xA7 after the edge in both builds.
REQ-034 Display test: SCAN_DIV=4, reg[1]=0x3C, reg[2]=0xF0, addrRa=1, addrRb=2 -> every 4 cycles An steps 0xE, 0xD, 0xB, 0x7, with SSeg 0x46, 0x30, 0x40, 0x0E, then wraps to 0xE.
REQ-035 Reset/write priority test: rst=0 with regWrite=1, addrW=2, datW=0xFF -> reg[2]=0 after the edge; asserting rst=0 mid-scan -> An=0xF on the next edge.
